// File: rtl/router_pkg.sv
// Shared router definitions: default datapath widths and header field helpers.
package router_pkg;

   localparam int DATA_W_DEF    = 8;
   localparam int NUM_CH_DEF    = 3;
   localparam int ADDR_W_DEF    = 2;
   localparam int LEN_W_DEF     = DATA_W_DEF - ADDR_W_DEF;
   localparam int ERR_CNT_W_DEF = 8;

   // Address field sits in the low addr_w bits of the header byte.
   function automatic logic [31:0] hdr_addr(input logic [31:0] hdr, input int addr_w);
      return hdr & ((32'd1 << addr_w) - 32'd1);
   endfunction

   // Length field is everything above the address field.
   function automatic logic [31:0] hdr_len(input logic [31:0] hdr, input int addr_w);
      return hdr >> addr_w;
   endfunction

endpackage

// File: rtl/router_pkt_check.sv
// Packet integrity checker: XOR parity, payload count, parity-byte capture and sticky errors.
// The err_count counter exists only when ROUTER_REG_ERR_CNT_EN is defined.
module router_pkt_check
   import router_pkg::*;
#(
   parameter int DATA_W    = DATA_W_DEF,
   parameter int ADDR_W    = ADDR_W_DEF,
   parameter int LEN_W     = DATA_W - ADDR_W,
   parameter int ERR_CNT_W = ERR_CNT_W_DEF
) (
   input  logic                 clock,
   input  logic                 resetn,
   input  logic                 pkt_valid,
   input  logic [DATA_W-1:0]    data_in,
   input  logic                 detect_add,
   input  logic                 lfd_state,
   input  logic                 ld_state,
   input  logic                 full_state,
   input  logic                 low_pkt_valid,
   input  logic                 parity_done,
   input  logic [DATA_W-1:0]    header_q,
   input  logic                 err_cnt_clr,
   output logic                 err,
   output logic                 len_err,
   output logic [ERR_CNT_W-1:0] err_count
);

   logic [DATA_W-1:0] par_q;
   logic [DATA_W-1:0] pkt_par_q;
   logic [LEN_W-1:0]  cnt;
   logic              parity_done_d;
   logic              chk;
   logic              par_mis;
   logic              len_mis;
   logic              payload_beat;

   assign payload_beat = ld_state & pkt_valid & ~full_state;
   assign chk          = parity_done & ~parity_done_d;
   assign par_mis      = (pkt_par_q != par_q);
   assign len_mis      = (cnt != LEN_W'(hdr_len(32'(header_q), ADDR_W)));

   always_ff @(posedge clock) begin
      if (!resetn) begin
         par_q <= '0;
         cnt   <= '0;
      end else if (lfd_state) begin
         par_q <= header_q;
         cnt   <= '0;
      end else if (payload_beat) begin
         par_q <= par_q ^ data_in;
         if (cnt != '1)
            cnt <= cnt + LEN_W'(1);
      end
   end

   // Only the first byte seen after pkt_valid drops is the packet's parity byte.
   always_ff @(posedge clock) begin
      if (!resetn)
         pkt_par_q <= '0;
      else if (ld_state && !pkt_valid && !low_pkt_valid)
         pkt_par_q <= data_in;
   end

   always_ff @(posedge clock) begin
      if (!resetn)
         parity_done_d <= 1'b0;
      else
         parity_done_d <= parity_done;
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         err     <= 1'b0;
         len_err <= 1'b0;
      end else if (chk) begin
         err     <= par_mis;
         len_err <= len_mis;
      end else if (detect_add) begin
         err     <= 1'b0;
         len_err <= 1'b0;
      end
   end

`ifdef ROUTER_REG_ERR_CNT_EN
   logic [ERR_CNT_W-1:0] err_cnt_q;

   always_ff @(posedge clock) begin
      if (!resetn)
         err_cnt_q <= '0;
      else if (err_cnt_clr)
         err_cnt_q <= '0;
      else if (chk && (par_mis || len_mis) && (err_cnt_q != '1))
         err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
   end

   assign err_count = err_cnt_q;
`else
   logic unused_err_cnt_clr;

   assign unused_err_cnt_clr = err_cnt_clr;
   assign err_count          = '0;
`endif

endmodule

// File: rtl/router_pkt_reg.sv
// Router packet register: header latch, FFS byte, registered dout bus and packet flags.
// Optional error counter enabled by defining ROUTER_REG_ERR_CNT_EN.
module router_pkt_reg
   import router_pkg::*;
#(
   parameter int DATA_W    = DATA_W_DEF,
   parameter int NUM_CH    = NUM_CH_DEF,
   parameter int ADDR_W    = ADDR_W_DEF,
   parameter int ERR_CNT_W = ERR_CNT_W_DEF
) (
   input  logic                 clock,
   input  logic                 resetn,
   input  logic                 pkt_valid,
   input  logic [DATA_W-1:0]    data_in,
   input  logic                 fifo_full,
   input  logic                 detect_add,
   input  logic                 lfd_state,
   input  logic                 ld_state,
   input  logic                 laf_state,
   input  logic                 full_state,
   input  logic                 rst_int_reg,
   input  logic                 err_cnt_clr,
   output logic [DATA_W-1:0]    dout,
   output logic                 dout_valid,
   output logic                 parity_done,
   output logic                 low_pkt_valid,
   output logic                 err,
   output logic                 len_err,
   output logic [ADDR_W-1:0]    dest_addr,
   output logic                 addr_invalid,
   output logic [ERR_CNT_W-1:0] err_count
);

   localparam int          LEN_W    = DATA_W - ADDR_W;
   localparam logic [31:0] NUM_CH_U = 32'(NUM_CH);

   logic [DATA_W-1:0] header_q;
   logic [DATA_W-1:0] ffs_q;
   logic [31:0]       in_addr;

   assign in_addr = hdr_addr(32'(data_in), ADDR_W);

   always_ff @(posedge clock) begin
      if (!resetn) begin
         header_q     <= '0;
         dest_addr    <= '0;
         addr_invalid <= 1'b0;
      end else if (detect_add && pkt_valid) begin
         header_q     <= data_in;
         dest_addr    <= ADDR_W'(in_addr);
         addr_invalid <= (in_addr >= NUM_CH_U);
      end
   end

   // Byte that arrived while the FIFO was full; replayed in laf_state.
   always_ff @(posedge clock) begin
      if (!resetn)
         ffs_q <= '0;
      else if (ld_state && fifo_full)
         ffs_q <= data_in;
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         dout       <= '0;
         dout_valid <= 1'b0;
      end else begin
         dout_valid <= 1'b1;
         if (lfd_state)
            dout <= header_q;
         else if (ld_state && !fifo_full)
            dout <= data_in;
         else if (laf_state)
            dout <= ffs_q;
         else
            dout_valid <= 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (!resetn)
         low_pkt_valid <= 1'b0;
      else if (rst_int_reg)
         low_pkt_valid <= 1'b0;
      else if (ld_state && !pkt_valid)
         low_pkt_valid <= 1'b1;
   end

   // Tail is done either directly in load or after the laf replay once the source went quiet.
   always_ff @(posedge clock) begin
      if (!resetn)
         parity_done <= 1'b0;
      else if ((ld_state && !pkt_valid && !fifo_full) ||
               (laf_state && low_pkt_valid && !parity_done))
         parity_done <= 1'b1;
      else if (detect_add)
         parity_done <= 1'b0;
   end

   router_pkt_check #(
      .DATA_W    (DATA_W),
      .ADDR_W    (ADDR_W),
      .LEN_W     (LEN_W),
      .ERR_CNT_W (ERR_CNT_W)
   ) u_check (
      .clock         (clock),
      .resetn        (resetn),
      .pkt_valid     (pkt_valid),
      .data_in       (data_in),
      .detect_add    (detect_add),
      .lfd_state     (lfd_state),
      .ld_state      (ld_state),
      .full_state    (full_state),
      .low_pkt_valid (low_pkt_valid),
      .parity_done   (parity_done),
      .header_q      (header_q),
      .err_cnt_clr   (err_cnt_clr),
      .err           (err),
      .len_err       (len_err),
      .err_count     (err_count)
   );

endmodule
